// File: rtl/act_sparse_encode_unit.sv
// Sparse activation encoder: dense 16-element block in, (value, index) beats out.
// Optional ACT_ENC_RELU_EN macro also drops negative elements from the stream.
module act_sparse_encode_unit #(
  parameter int DATA_WIDTH   = 8,
  parameter int BLOCK_NUMBER = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] Input_act_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [DATA_WIDTH-1:0]              Output_act_data,
  output logic [3:0]                         mask,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               out_zero
);

  localparam int DW = DATA_WIDTH;
  localparam int BN = BLOCK_NUMBER;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [BN*DW-1:0]   blk_q, blk_d;
  logic [BN-1:0]      rem_q, rem_d;
  logic [DW-1:0]      data_q, data_d;
  logic [3:0]         mask_q, mask_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               zero_q, zero_d;

  logic               hs;
  logic               accept;
  logic [BN-1:0]      nz;
  logic [3:0]         idx;

  // Elements that produce a beat.
  function automatic logic [BN-1:0] nz_map(
    input logic [BN*DW-1:0] b
  );
    logic [DW-1:0] e;
    nz_map = '0;
    for (int i = 0; i < BN; i++) begin
      e = b[i*DW +: DW];
`ifdef ACT_ENC_RELU_EN
      nz_map[i] = (e != '0) && !e[DW-1];
`else
      nz_map[i] = (e != '0);
`endif
    end
  endfunction

  // Index of the lowest set bit (0 when none).
  function automatic logic [3:0] low_idx(
    input logic [BN-1:0] v
  );
    low_idx = '0;
    for (int i = BN - 1; i >= 0; i--) begin
      if (v[i]) low_idx = 4'(i);
    end
  endfunction

  // Next-beat selection, block capture and handshake control.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    rem_d   = rem_q;
    data_d  = data_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    last_d  = last_q;
    zero_d  = zero_q;
    nz      = '0;
    idx     = '0;
    hs       = valid_q && out_ready;
    in_ready = (state_q == IDLE) || (hs && last_q);
    accept   = in_valid && in_ready;
    if (accept) begin
      nz      = nz_map(Input_act_data);
      idx     = low_idx(nz);
      blk_d   = Input_act_data;
      state_d = EMIT;
      valid_d = 1'b1;
      if (nz == '0) begin
        data_d = '0;
        mask_d = '0;
        rem_d  = '0;
        last_d = 1'b1;
        zero_d = 1'b1;
      end else begin
        data_d = Input_act_data[idx*DW +: DW];
        mask_d = idx;
        rem_d  = nz & (nz - 1'b1);
        last_d = (rem_d == '0);
        zero_d = 1'b0;
      end
    end else if (hs) begin
      if (last_q) begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        zero_d  = 1'b0;
      end else begin
        idx    = low_idx(rem_q);
        data_d = blk_q[idx*DW +: DW];
        mask_d = idx;
        rem_d  = rem_q & (rem_q - 1'b1);
        last_d = (rem_d == '0);
        zero_d = 1'b0;
      end
    end
  end

  // State and registered beat outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      zero_q  <= zero_d;
    end
  end

  assign Output_act_data = data_q;
  assign mask            = mask_q;
  assign out_valid       = valid_q;
  assign out_last        = last_q;
  assign out_zero        = zero_q;

endmodule

// File: tb/tb_act_sparse_encode_unit.sv
// Directed bench for act_sparse_encode_unit.
// Honours ACT_ENC_RELU_EN when building expectations.
module tb_act_sparse_encode_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   dout;
  logic [3:0]   mask;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         out_zero;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  act_sparse_encode_unit dut (
    .clk             (clk),
    .rst             (rst),
    .Input_act_data  (din),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .Output_act_data (dout),
    .mask            (mask),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .out_zero        (out_zero)
  );

  typedef struct {
    logic [127:0] blk;
    int           n;
    logic [63:0]  masks;
    logic         zero;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] put(input logic [127:0] b,
                                       input int i,
                                       input logic [7:0] v);
    logic [127:0] r;
    r = b;
    r[i*8 +: 8] = v;
    return r;
  endfunction

  task automatic accept_block(input logic [127:0] b);
    @(negedge clk);
    din = b;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    din = '0;
  endtask

  initial begin
    logic [127:0] b;
    logic [3:0]   m;
    logic [7:0]   ed;
    logic [7:0]   hd;
    logic [3:0]   hm;
    logic         hl;

    rst = 1'b1;
    din = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    b = '0;
    b = put(b, 3, 8'h11);
    b = put(b, 7, 8'h22);
    b = put(b, 15, 8'h33);
    vecs[0] = '{b, 3, 64'hF73, 1'b0};
    vecs[1] = '{128'h0, 1, 64'h0, 1'b1};
    b = put('0, 0, 8'h7F);
    vecs[2] = '{b, 1, 64'h0, 1'b0};
    b = put('0, 15, 8'h01);
    vecs[3] = '{b, 1, 64'hF, 1'b0};
    b = put('0, 0, 8'h80);
    b = put(b, 1, 8'hFF);
    b = put(b, 2, 8'h05);
`ifdef ACT_ENC_RELU_EN
    vecs[4] = '{b, 1, 64'h2, 1'b0};
    vecs[5] = '{put('0, 8, 8'h80), 1, 64'h0, 1'b1};
`else
    vecs[4] = '{b, 3, 64'h210, 1'b0};
    vecs[5] = '{put('0, 8, 8'h80), 1, 64'h8, 1'b0};
`endif

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(dout), 0);
    chk("rst_mask", 32'(mask), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_zero", 32'(out_zero), 0);
    rst = 1'b0;

    // Table-driven blocks with out_ready held high.
    for (int v = 0; v < 6; v++) begin
      accept_block(vecs[v].blk);
      for (int k = 0; k < vecs[v].n; k++) begin
        m  = vecs[v].masks[k*4 +: 4];
        b  = vecs[v].blk;
        ed = vecs[v].zero ? 8'h00 : b[m*8 +: 8];
        chk($sformatf("v%0d_b%0d_valid", v, k), 32'(out_valid), 1);
        chk($sformatf("v%0d_b%0d_data", v, k), 32'(dout), 32'(ed));
        chk($sformatf("v%0d_b%0d_mask", v, k), 32'(mask), 32'(m));
        chk($sformatf("v%0d_b%0d_last", v, k), 32'(out_last),
            32'(k == vecs[v].n - 1));
        chk($sformatf("v%0d_b%0d_zero", v, k), 32'(out_zero),
            32'(vecs[v].zero));
        chk($sformatf("v%0d_b%0d_in_ready", v, k), 32'(in_ready),
            32'(k == vecs[v].n - 1));
        @(negedge clk);
      end
      chk($sformatf("v%0d_idle", v), 32'(out_valid), 0);
    end

    // Dense block, out_ready toggling 0/1.
    b = '0;
    for (int i = 0; i < 16; i++) b = put(b, i, 8'(i + 1));
    accept_block(b);
    for (int k = 0; k < 16; k++) begin
      out_ready = 1'b0;
      chk($sformatf("d%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("d%0d_mask", k), 32'(mask), 32'(k));
      chk($sformatf("d%0d_data", k), 32'(dout), 32'(k + 1));
      chk($sformatf("d%0d_last", k), 32'(out_last), 32'(k == 15));
      hd = dout;
      hm = mask;
      hl = out_last;
      @(negedge clk);
      chk($sformatf("d%0d_hold_valid", k), 32'(out_valid), 1);
      chk($sformatf("d%0d_hold_data", k), 32'(dout), 32'(hd));
      chk($sformatf("d%0d_hold_mask", k), 32'(mask), 32'(hm));
      chk($sformatf("d%0d_hold_last", k), 32'(out_last), 32'(hl));
      out_ready = 1'b1;
      @(negedge clk);
    end
    chk("dense_idle", 32'(out_valid), 0);

    // Back-to-back blocks with in_valid held high.
    @(negedge clk);
    din = put(put('0, 0, 8'h0A), 5, 8'h0B);
    in_valid = 1'b1;
    @(negedge clk);
    din = put('0, 2, 8'h0C);
    chk("b2b_a0_mask", 32'(mask), 0);
    chk("b2b_a0_data", 32'(dout), 32'h0A);
    chk("b2b_a0_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("b2b_a1_mask", 32'(mask), 5);
    chk("b2b_a1_last", 32'(out_last), 1);
    chk("b2b_a1_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    din = '0;
    chk("b2b_b0_valid", 32'(out_valid), 1);
    chk("b2b_b0_data", 32'(dout), 32'h0C);
    chk("b2b_b0_mask", 32'(mask), 2);
    chk("b2b_b0_last", 32'(out_last), 1);
    @(negedge clk);
    chk("b2b_idle", 32'(out_valid), 0);

    // Reset after the first of three beats.
    b = put(put(put('0, 1, 8'h01), 4, 8'h02), 9, 8'h03);
    accept_block(b);
    chk("rst_seq_b0_mask", 32'(mask), 1);
    @(negedge clk);
    chk("rst_seq_b1_mask", 32'(mask), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_seq_valid", 32'(out_valid), 0);
    chk("rst_seq_in_ready", 32'(in_ready), 1);
    chk("rst_seq_mask", 32'(mask), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_seq_quiet%0d", i), 32'(out_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
